// File: rtl/button_debounce.sv
// Push-button conditioner: per-bit 2-FF synchroniser and tick-paced debounce FSM
// producing a clean level plus single-cycle pressed/released pulses.
module button_debounce #(
  parameter int WIDTH        = 4,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_COUNT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] buttons_in,
  output logic [WIDTH-1:0] buttons_level,
  output logic [WIDTH-1:0] buttons_pressed,
  output logic [WIDTH-1:0] buttons_released
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_COUNT - 1);

  typedef enum logic [1:0] {ST_LOW, ST_RISE, ST_HIGH, ST_FALL} state_t;

  logic [PW-1:0]    presc_reg;
  logic             tick;
  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;

  // One shared prescaler keeps every bit sampling on the same tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg <= '0;
    end else if (presc_reg == PRESC_LAST) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  assign tick = (presc_reg == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= buttons_in;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      state_t        state_reg;
      logic [CW-1:0] cnt_reg;
      logic          level_reg;
      logic          pressed_reg;
      logic          released_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg    <= ST_LOW;
          cnt_reg      <= '0;
          level_reg    <= 1'b0;
          pressed_reg  <= 1'b0;
          released_reg <= 1'b0;
        end else begin
          pressed_reg  <= 1'b0;
          released_reg <= 1'b0;
          if (tick) begin
            case (state_reg)
              ST_LOW: begin
                if (sync2_reg[gi]) begin
                  if (STABLE_COUNT == 1) begin
                    state_reg   <= ST_HIGH;
                    level_reg   <= 1'b1;
                    pressed_reg <= 1'b1;
                  end else begin
                    state_reg <= ST_RISE;
                    cnt_reg   <= CW'(1);
                  end
                end
              end
              ST_RISE: begin
                if (!sync2_reg[gi]) begin
                  state_reg <= ST_LOW;
                  cnt_reg   <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                  state_reg   <= ST_HIGH;
                  cnt_reg     <= '0;
                  level_reg   <= 1'b1;
                  pressed_reg <= 1'b1;
                end else begin
                  cnt_reg <= cnt_reg + CW'(1);
                end
              end
              ST_HIGH: begin
                if (!sync2_reg[gi]) begin
                  if (STABLE_COUNT == 1) begin
                    state_reg    <= ST_LOW;
                    level_reg    <= 1'b0;
                    released_reg <= 1'b1;
                  end else begin
                    state_reg <= ST_FALL;
                    cnt_reg   <= CW'(1);
                  end
                end
              end
              ST_FALL: begin
                if (sync2_reg[gi]) begin
                  state_reg <= ST_HIGH;
                  cnt_reg   <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                  state_reg    <= ST_LOW;
                  cnt_reg      <= '0;
                  level_reg    <= 1'b0;
                  released_reg <= 1'b1;
                end else begin
                  cnt_reg <= cnt_reg + CW'(1);
                end
              end
              default: begin
                state_reg <= ST_LOW;
                cnt_reg   <= '0;
              end
            endcase
          end
        end
      end

      assign buttons_level[gi]    = level_reg;
      assign buttons_pressed[gi]  = pressed_reg;
      assign buttons_released[gi] = released_reg;
    end
  endgenerate

endmodule

// File: tb/tb_button_debounce.sv
// Randomised and directed bench for button_debounce; a run-length reference model
// predicts pulses into a queue that an independent monitor drains and compares.
module tb_button_debounce;
  localparam int W  = 4;
  localparam int TD = 4;
  localparam int SC = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] buttons_in = 4'hF;
  logic [W-1:0] buttons_level;
  logic [W-1:0] buttons_pressed;
  logic [W-1:0] buttons_released;

  button_debounce #(.WIDTH(W), .TICK_DIV(TD), .STABLE_COUNT(SC)) dut (
    .clk              (clk),
    .reset            (reset),
    .buttons_in       (buttons_in),
    .buttons_level    (buttons_level),
    .buttons_pressed  (buttons_pressed),
    .buttons_released (buttons_released)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [W-1:0] p;
    logic [W-1:0] r;
  } ev_t;

  ev_t          evq[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           n_since_reset = 0;
  logic [W-1:0] exp_level = '0;
  int           run [W];
  logic [W-1:0] seen [$];  // inputs as seen at recent edges, newest first

  // Reference: input seen two edges late; every TD-th edge after reset samples it;
  // SC consecutive samples disagreeing with the current level flip that level.
  always @(posedge clk) begin
    logic [W-1:0] s, p, r;
    logic         tk;
    cyc++;
    p = '0;
    r = '0;
    if (reset) begin
      n_since_reset = 0;
      exp_level = '0;
      for (int b = 0; b < W; b++) run[b] = 0;
      seen.delete();
    end else begin
      tk = ((n_since_reset % TD) == TD - 1);
      n_since_reset++;
      s = (seen.size() >= 2) ? seen[1] : '0;
      if (tk) begin
        for (int b = 0; b < W; b++) begin
          if (s[b] != exp_level[b]) begin
            run[b]++;
            if (run[b] == SC) begin
              exp_level[b] = s[b];
              run[b] = 0;
              if (s[b]) p[b] = 1'b1;
              else r[b] = 1'b1;
            end
          end else begin
            run[b] = 0;
          end
        end
      end
      if ((p | r) != '0) evq.push_back('{cyc: cyc, p: p, r: r});
      seen.push_front(buttons_in);
      if (seen.size() > 2) void'(seen.pop_back());
    end
  end

  // Monitor: compares level every cycle and matches each pulse against the queue.
  always @(negedge clk) begin
    ev_t e;
    if (cyc > 0) begin
      total++;
      if (buttons_level !== exp_level) begin
        bad++;
        $display("FAIL level cyc=%0d got=%h want=%h", cyc, buttons_level, exp_level);
      end
      total++;
      if ((buttons_pressed & buttons_released) !== '0) begin
        bad++;
        $display("FAIL overlap cyc=%0d pressed=%h released=%h want no common bit",
                 cyc, buttons_pressed, buttons_released);
      end
      if ((buttons_pressed | buttons_released) !== '0) begin
        total++;
        if (evq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse cyc=%0d pressed=%h released=%h want none",
                   cyc, buttons_pressed, buttons_released);
        end else begin
          e = evq.pop_front();
          if (e.cyc != cyc || e.p !== buttons_pressed || e.r !== buttons_released) begin
            bad++;
            $display("FAIL pulse cyc=%0d pressed=%h released=%h want cyc=%0d pressed=%h released=%h",
                     cyc, buttons_pressed, buttons_released, e.cyc, e.p, e.r);
          end else begin
            $display("pulse cyc=%0d pressed=%h released=%h level=%h",
                     cyc, buttons_pressed, buttons_released, buttons_level);
          end
        end
      end else if (evq.size() > 0 && evq[0].cyc <= cyc) begin
        total++;
        bad++;
        e = evq.pop_front();
        $display("FAIL missing_pulse cyc=%0d got none want pressed=%h released=%h",
                 cyc, e.p, e.r);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Measures clocks from now until level[b] equals val; 999 on timeout.
  task automatic level_latency(input int b, input logic val, output int lat);
    int k0;
    k0 = cyc;
    lat = 999;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (buttons_level[b] == val) begin
        lat = cyc - k0;
        break;
      end
    end
  endtask

  initial begin
    int lat, cnt, k;
    logic in_range;
    // 1: reset held with all buttons pressed
    step(10);
    reset = 1'b0;
    buttons_in = '0;
    step(1);
    check("post_reset_level", int'(buttons_level), 0);
    check("post_reset_pulses", int'(buttons_pressed | buttons_released), 0);
    step(20);

    // 2: raise bit0
    buttons_in[0] = 1'b1;
    level_latency(0, 1'b1, lat);
    in_range = (lat >= 11 && lat <= 15);
    if (!in_range) $display("rise latency %0d", lat);
    check("rise_latency_in_11_15", int'(in_range), 1);
    step(10);

    // 3: bouncing bit1, then settled high
    cnt = 0;
    for (int i = 0; i < 42; i++) begin
      if (i < 36 && (i % 3) == 0) buttons_in[1] = ~buttons_in[1];
      if (i == 36) buttons_in[1] = 1'b1;
      step(1);
      if (buttons_pressed[1]) cnt++;
    end
    check("bounce_no_pulse", cnt, 0);
    for (int i = 0; i < 25; i++) begin
      step(1);
      if (buttons_pressed[1]) cnt++;
    end
    check("bounce_one_press", cnt, 1);
    check("bounce_level", int'(buttons_level[1]), 1);

    // 4: drop bit0
    buttons_in[0] = 1'b0;
    level_latency(0, 1'b0, lat);
    in_range = (lat >= 11 && lat <= 15);
    if (!in_range) $display("fall latency %0d", lat);
    check("fall_latency_in_11_15", int'(in_range), 1);
    step(5);

    // 5: all bits together
    buttons_in = '0;
    step(30);
    buttons_in = 4'hF;
    k = 0;
    while (buttons_pressed == '0 && k < 30) begin
      step(1);
      k++;
    end
    check("all_pressed_mask", int'(buttons_pressed), 15);
    check("all_level", int'(buttons_level), 15);
    step(5);

    // 6: reset in the middle of debouncing bit2
    buttons_in = '0;
    step(30);
    buttons_in[2] = 1'b1;
    k = 0;
    while (run[2] != 2 && k < 40) begin
      step(1);
      k++;
    end
    check("reach_second_tick", int'(run[2] == 2), 1);
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    k = 0;
    while (!buttons_pressed[2] && k < 40) begin
      step(1);
      k++;
    end
    check("press_after_reset_delay", k, 3 * TD);

    // Random phase: alternating bouncy and calm segments with occasional resets
    for (int seg = 0; seg < 16; seg++) begin
      for (int i = 0; i < 40; i++) begin
        for (int b = 0; b < W; b++)
          if ($urandom_range(0, (seg % 2 == 0) ? 3 : 29) == 0) buttons_in[b] = ~buttons_in[b];
        reset = ($urandom_range(0, 249) == 0);
        step(1);
      end
    end
    reset = 1'b0;
    step(60);
    check("queue_drained", evq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
